config_port_arbiter: RTL and testbench
======================================

Name: config_port_arbiter

Overview:
- Shares the single fabric configuration word port between several configuration sources: UART loader, USB DFU endpoint, and SPI-flash boot reader.
- Sits in the 12 MHz system domain, between the source engines and the bitstream write interface of the configuration block.
- Grants one source at a time with round-robin fairness.
- Holds the grant for a whole bitstream. Releases on done, on request drop, or on inactivity timeout.

Parameters:
- NUM_REQ, 3: number of requesting sources. Index 0 = SPI flash, 1 = UART, 2 = USB DFU.
- DATA_WIDTH, 32: configuration word width.
- TIMEOUT_CYCLES, 12000: idle cycles before a forced release (1 ms at 12 MHz). Must be >= 2.
- TIMEOUT_W, 16: timeout counter width. Must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk_system_i  in  1  system clock, 12 MHz.
- reset_n_i  in  1  asynchronous active-low reset.
- req_i  in  NUM_REQ  per-source level request to own the port.
- done_i  in  NUM_REQ  per-source one-cycle end-of-bitstream pulse.
- valid_i  in  NUM_REQ  per-source word valid.
- data_i  in  NUM_REQ*DATA_WIDTH  per-source word; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- ready_o  out  NUM_REQ  per-source word accept.
- grant_o  out  NUM_REQ  one-hot current owner.
- cfg_data_o  out  DATA_WIDTH  word to the config block.
- cfg_valid_o  out  1  word valid to the config block.
- cfg_ready_i  in  1  config block accept.
- busy_o  out  1  high when state is not IDLE.
- timeout_o  out  1  one-cycle pulse on forced release.

Behaviour:
- Clock, reset and outputs:
  - Single clock domain; all flops reset asynchronously on reset_n_i low.
  - Reset values: grant_o=0, ready_o=0, cfg_valid_o=0, cfg_data_o=0, busy_o=0, timeout_o=0.
  - Reset values of internal state: round-robin pointer last=NUM_REQ-1, timeout counter=0, state=IDLE.
- State IDLE:
  - If any req_i bit is set, select the first set bit searching upward from last+1, wrapping modulo NUM_REQ.
  - Register grant_o one-hot, update last to the selected index, go to GRANT.
  - Grant is visible in the cycle after req_i is sampled (1-cycle latency).
- State GRANT (owner g):
  - ready_o[g] = !cfg_valid_o | cfg_ready_i. This is combinational from registered state and cfg_ready_i. All other ready_o bits are 0.
  - A beat transfers when valid_i[g] & ready_o[g]. On the next edge cfg_data_o takes data_i slice g and cfg_valid_o=1.
  - Words are never dropped or duplicated, and order is preserved.
  - Full throughput: one word per cycle while cfg_ready_i=1.
  - The output register clears (cfg_valid_o=0) on cfg_valid_o & cfg_ready_i when no new beat arrives in the same cycle.
- Timeout counter:
  - Clears on each transferred beat. Increments each GRANT cycle without a beat.
  - Counter does not increment while cfg_valid_o & !cfg_ready_i, because a stalled sink is not source inactivity.
- Release from GRANT to DRAIN, with ready_o forced to 0 from the next cycle:
  - done_i[g]=1. A beat presented in the same cycle is still transferred.
  - req_i[g]=0.
  - Counter reaches TIMEOUT_CYCLES. In this case timeout_o pulses for exactly one cycle, on the cycle DRAIN is entered.
- done_i or req_i drop from non-owners: ignored; no effect.
- State DRAIN:
  - Wait until cfg_valid_o=0. Then clear grant_o and counter, and go to IDLE.
  - A new grant requires at least one IDLE cycle.
  - If cfg_valid_o is already 0 on entry, DRAIN lasts one cycle.
- Fairness:
  - With all sources requesting continuously, grants rotate 0,1,2,0,...
  - A source re-requesting immediately after release waits behind the other pending requesters.
- Reset mid-transfer: everything returns to reset values at once. A partial word in the output register is discarded.

Test Plan:
- Reset, then req_i=3'b010, three beats 0xA0000001..3 with cfg_ready_i=1, then done_i[1]
  -> grant_o=3'b010 one cycle after req.
  -> cfg_data_o shows the three words on consecutive cycles.
  -> busy_o falls two cycles after done.
- req_i=3'b111 held, each owner sends 1 beat then pulses done
  -> grant order 001, 010, 100, 001.
  -> one IDLE cycle between grants.
- Owner 2 granted, cfg_ready_i=0 for 20 cycles with valid_i[2]=1
  -> cfg_data_o held stable, ready_o[2]=0 while stalled.
  -> no timeout.
  -> after release, the next word follows with no loss.
- TIMEOUT_CYCLES=8, owner 0 sends 1 beat then stays idle
  -> timeout_o pulses once, 9 cycles after the beat.
  -> grant_o=0 one cycle later.
- done_i[0] pulsed while owner is 1, and req_i[0] toggled
  -> owner 1 grant unaffected, no extra cfg beats.
- reset_n_i asserted low while cfg_valid_o=1 and owner=2
  -> all outputs 0 asynchronously.
  -> after release, req_i=3'b100 is re-granted from last=NUM_REQ-1, i.e. search starts at source 0.

Source files
------------

// File: rtl/config_port_arbiter.sv
// Round-robin owner arbitration for the shared fabric configuration word port.
// A grant is held for a whole bitstream and released on done, request drop or idle timeout.
module config_port_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_W      = 16
) (
  input  logic                          clk_system_i,
  input  logic                          reset_n_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            done_i,
  input  logic [NUM_REQ-1:0]            valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ready_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [DATA_WIDTH-1:0]         cfg_data_o,
  output logic                          cfg_valid_o,
  input  logic                          cfg_ready_i,
  output logic                          busy_o,
  output logic                          timeout_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0]     LAST_RST    = IDX_W'(NUM_REQ - 1);
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

  logic [1:0]            state;
  logic [IDX_W-1:0]      last;
  logic [IDX_W-1:0]      owner;
  logic [TIMEOUT_W-1:0]  idle_cnt;

  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      pick;
  logic                  pick_found;

  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_req;
  logic                  owner_done;
  logic                  owner_valid;
  logic                  in_grant;
  logic                  slot_free;
  logic                  beat;
  logic                  stalled;
  logic [TIMEOUT_W-1:0]  cnt_inc;
  logic                  idle_hit;
  logic                  release_now;

  // First requester strictly after the previous owner, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick       = last;
    cand       = last;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last) + i) % NUM_REQ);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner == IDX_W'(k)) begin
        owner_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign owner_req   = req_i[owner];
  assign owner_done  = done_i[owner];
  assign owner_valid = valid_i[owner];

  assign in_grant  = (state == ST_GRANT);
  assign slot_free = !cfg_valid_o || cfg_ready_i;
  assign beat      = in_grant && owner_valid && slot_free;
  assign stalled   = cfg_valid_o && !cfg_ready_i;
  assign cnt_inc   = idle_cnt + TIMEOUT_W'(1);

  // A back-pressured sink is not source inactivity, so the timer pauses then.
  assign idle_hit    = in_grant && !beat && !stalled && (cnt_inc == TIMEOUT_MAX);
  assign release_now = owner_done || !owner_req || idle_hit;

  always_comb begin
    ready_o = '0;
    if (in_grant) begin
      ready_o[owner] = slot_free;
    end
  end

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk_system_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= ST_IDLE;
      last        <= LAST_RST;
      owner       <= '0;
      grant_o     <= '0;
      idle_cnt    <= '0;
      cfg_data_o  <= '0;
      cfg_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;

      if (beat) begin
        cfg_data_o  <= owner_data;
        cfg_valid_o <= 1'b1;
      end else if (cfg_ready_i) begin
        cfg_valid_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_o <= NUM_REQ'(1) << pick;
            last    <= pick;
            owner   <= pick;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (beat) begin
            idle_cnt <= '0;
          end else if (!stalled) begin
            idle_cnt <= cnt_inc;
          end
          if (release_now) begin
            state     <= ST_DRAIN;
            timeout_o <= idle_hit;
          end
        end
        ST_DRAIN: begin
          if (!cfg_valid_o) begin
            grant_o  <= '0;
            idle_cnt <= '0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed bench for config_port_arbiter: stimulus pushes expected config words,
// a negedge monitor pops them as the sink accepts words.
module tb_config_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [2:0]  done;
  logic [2:0]  valid;
  logic [95:0] data;
  logic [2:0]  ready;
  logic [2:0]  grant;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        busy;
  logic        timeout;

  int checks       = 0;
  int failures     = 0;
  int timeout_seen = 0;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  config_port_arbiter #(
    .NUM_REQ       (3),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_W     (4)
  ) dut (
    .clk_system_i(clk),
    .reset_n_i   (rst_n),
    .req_i       (req),
    .done_i      (done),
    .valid_i     (valid),
    .data_i      (data),
    .ready_o     (ready),
    .grant_o     (grant),
    .cfg_data_o  (cfg_data),
    .cfg_valid_o (cfg_valid),
    .cfg_ready_i (cfg_ready),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cfg_valid && cfg_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cfg_word_unexpected actual=%0h required=none", cfg_data);
      end else begin
        mon_exp = sb.pop_front();
        check("cfg_word", {32'd0, cfg_data}, {32'd0, mon_exp});
      end
    end
    if (timeout) timeout_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic send_beat(input int src, input logic [31:0] w, input bit push);
    int n;
    valid[src] = 1'b1;
    data[src*32 +: 32] = w;
    if (push) sb.push_back(w);
    n = 0;
    #1;
    while (!ready[src] && n < 32) begin
      tick();
      n++;
    end
    check("beat_wait_expired", {63'd0, (n >= 32)}, 64'd0);
    tick();
    valid[src] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = '0; done = '0; valid = '0; data = '0; cfg_ready = 1'b1;
    tick();
    tick();
    check("rst_grant", grant, 0);
    check("rst_ready", ready, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_cfg_data", cfg_data, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    tick();

    // single owner, three back-to-back words, then done
    req = 3'b010;
    #1;
    check("t1_grant_before_edge", grant, 0);
    tick();
    check("t1_grant", grant, 3'b010);
    check("t1_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      send_beat(1, 32'hA000_0001 + 32'(i), 1'b1);
      check("t1_word_cycle", cfg_data, 32'hA000_0001 + 32'(i));
      check("t1_word_valid", cfg_valid, 1);
    end
    done = 3'b010; req = 3'b000;
    tick();
    done = '0;
    check("t1_busy_drain", busy, 1);
    check("t1_ready_drain", ready, 0);
    tick();
    check("t1_busy_fall", busy, 0);
    check("t1_grant_clear", grant, 0);

    // rotation with everyone requesting
    apply_reset();
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t2_grant_order", grant, 3'b001 << (k % 3));
      send_beat(k % 3, 32'hB000_0000 + 32'(k), 1'b1);
      done = 3'b001 << (k % 3);
      tick();
      done = '0;
      tick();
      check("t2_idle_gap_grant", grant, 0);
      check("t2_idle_gap_busy", busy, 0);
    end
    req = '0;

    // owner 2 with a stalled sink
    req = 3'b100;
    tick();
    check("t3_grant", grant, 3'b100);
    send_beat(2, 32'hC000_0001, 1'b1);
    cfg_ready = 1'b0;
    valid[2] = 1'b1;
    data[64 +: 32] = 32'hC000_0002;
    sb.push_back(32'hC000_0002);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("t3_ready_stalled", ready[2], 0);
      check("t3_data_held", cfg_data, 32'hC000_0001);
      check("t3_valid_held", cfg_valid, 1);
      check("t3_no_timeout", timeout, 0);
      tick();
    end
    cfg_ready = 1'b1;
    #1;
    check("t3_ready_resume", ready[2], 1);
    tick();
    valid[2] = 1'b0;
    check("t3_next_word", cfg_data, 32'hC000_0002);
    check("t3_next_valid", cfg_valid, 1);
    check("t3_timeouts_so_far", timeout_seen, 0);
    done = 3'b100; req = '0;
    tick();
    done = '0;
    wait_idle();

    // owner 0 goes quiet after one word
    req = 3'b001;
    tick();
    check("t4_grant", grant, 3'b001);
    send_beat(0, 32'hD000_0001, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("t4_timeout_early", timeout, 0);
      tick();
    end
    check("t4_timeout_pulse", timeout, 1);
    check("t4_grant_in_drain", grant, 3'b001);
    req = '0;
    tick();
    check("t4_timeout_single", timeout, 0);
    check("t4_grant_clear", grant, 0);
    check("t4_busy_clear", busy, 0);

    // non-owner done/req activity
    req = 3'b010;
    tick();
    check("t5_grant", grant, 3'b010);
    done = 3'b001; req = 3'b011;
    tick();
    done = '0; req = 3'b010;
    check("t5_grant_kept_a", grant, 3'b010);
    check("t5_busy_a", busy, 1);
    check("t5_no_cfg_beat", cfg_valid, 0);
    req = 3'b011;
    tick();
    check("t5_grant_kept_b", grant, 3'b010);
    req = 3'b010;
    tick();
    check("t5_grant_kept_c", grant, 3'b010);
    send_beat(1, 32'hF000_0001, 1'b1);
    check("t5_word", cfg_data, 32'hF000_0001);
    done = 3'b010; req = '0;
    tick();
    done = '0;
    wait_idle();

    // reset while owner 2 holds a pending word
    req = 3'b100;
    tick();
    check("t6_grant", grant, 3'b100);
    cfg_ready = 1'b0;
    send_beat(2, 32'hE000_0001, 1'b0);
    check("t6_pending", cfg_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_grant", grant, 0);
    check("t6_async_ready", ready, 0);
    check("t6_async_valid", cfg_valid, 0);
    check("t6_async_data", cfg_data, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_timeout", timeout, 0);
    req = 3'b100;
    cfg_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_regrant", grant, 3'b100);
    done = 3'b100; req = '0;
    tick();
    done = '0;
    wait_idle();

    check("sb_empty", sb.size(), 0);
    check("timeout_count", timeout_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
